timer_set_datapath: RTL and testbench
=====================================

// Module: timer_set_datapath
// PURPOSE
//  Datapath under the timer-set PLA controller. Collects BCD keypad digits into a 4-digit
//  HHMM entry register and returns the key strobe t and validity flag k7 to the controller.
//  Applies the controller's La/Lb/Ea/Lr/Er/Kc/s strobes to the hour/min (A/B) and alarm (R)
//  registers. Drives the alarm-match output consumed by the display/buzzer stage.
// PARAMETERS
//  HOUR_MAX  23  highest legal BCD hour accepted by the k7 check
//  MIN_MAX   59  highest legal BCD minute accepted by the k7 check
//  MAX_KEYS  4   digits per entry; further keys ignored until Kc
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  rst_n      in   1   synchronous active-low reset
//  key_valid  in   1   one-cycle keypad strobe
//  key_code   in   4   key value; 0-9 digit, 10-15 ignored
//  now_hhmm   in   16  current time, BCD {H1,H0,M1,M0}
//  Kc         in   1   clear entry register and key count
//  La         in   1   load A <= entry[15:8]
//  Lb         in   1   load B <= entry[7:0]
//  Ea         in   1   enable {A,B} onto internal bus
//  s          in   2   R source mux select
//  Lr         in   1   load R from mux
//  Er         in   1   enable alarm compare
//  t          out  1   registered pulse: a digit was accepted
//  k7         out  1   entry complete and legal (registered)
//  a_q        out  8   hour register A, BCD
//  b_q        out  8   minute register B, BCD
//  r_q        out  16  alarm register R, BCD HHMM
//  alarm      out  1   registered alarm-match flag
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): entry=0, kcnt=0, t=0, k7=0, a_q=0, b_q=0, r_q=0, alarm=0.
//   Reset overrides every strobe in the same cycle.
//  Entry: on key_valid, key_code<=9 and kcnt<MAX_KEYS:
//   entry <= {entry[11:0],key_code}, kcnt++, and t=1 on the next cycle only.
//   Keys >9, or keys with kcnt==MAX_KEYS, change nothing and give t=0.
//  Kc: entry<=0, kcnt<=0. Kc wins over a key arriving in the same cycle; that key is lost, t=0.
//  k7 (registered) = kcnt==MAX_KEYS && entry[15:8]<=HOUR_MAX && entry[7:0]<=MIN_MAX
//   && each BCD nibble <=9. Updates one cycle after the entry changes.
//  La/Lb: load on the edge. La and Lb may be asserted together. Kc in the same cycle
//   still loads the pre-clear entry value.
//  Bus = Ea ? {a_q,b_q} : 16'h0000.
//  R mux by s: 00 bus, 01 now_hhmm, 10 16'h0000, 11 r_q (hold).
//   r_q <= mux only when Lr=1; otherwise hold.
//  Alarm: alarm <= Er && (r_q == now_hhmm). Cleared the cycle after Er drops.
//   Compare uses r_q before any same-cycle Lr.
//  Latency: key->t 1 cycle; key->k7 1 cycle after the 4th digit; strobe->register 1 edge.
//  Controller handshake: state2 raises Kc, state3 Lb, state4 La, state6 Ea+Lr, Er on
//   La|Lb. State 7 reads k7: 1 returns to idle, 0 re-enters clear. Combinational
//   loops between these strobes and k7/t are forbidden.
// TESTING
//  Reset: rst_n=0 with all strobes high -> all outputs 0 the next cycle.
//  Keys 1,2,3,0 -> t pulses 4x, entry=16'h1230, k7=1 one cycle after the 4th key.
//  Keys 2,5,0,0 -> k7=0 (hour 25). Keys 0,9,6,1 -> k7=0 (minute 61).
//   Kc then keys 0,7,4,5 -> k7=1.
//  5th key after 1230, key_code=4'hB, and Kc+key in the same cycle -> entry unchanged/cleared, t=0.
//  Entry 0745, La+Lb, then Ea+Lr with s=00 -> a_q=8'h07, b_q=8'h45, r_q=16'h0745.
//  r_q=0745, Er=1, now_hhmm 0744->0745->0746 -> alarm 0,1,0, each one cycle after the compare.

Source files
------------

// File: rtl/timer_set_datapath.sv
// timer_set_datapath: keypad HHMM entry, hour/min (A/B) and alarm (R) registers with alarm compare.
module timer_set_datapath #(
  parameter logic [7:0] HOUR_MAX = 8'h23,
  parameter logic [7:0] MIN_MAX  = 8'h59,
  parameter int         MAX_KEYS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic [15:0] now_hhmm,
  input  logic        Kc,
  input  logic        La,
  input  logic        Lb,
  input  logic        Ea,
  input  logic [1:0]  s,
  input  logic        Lr,
  input  logic        Er,
  output logic        t,
  output logic        k7,
  output logic [7:0]  a_q,
  output logic [7:0]  b_q,
  output logic [15:0] r_q,
  output logic        alarm
);
  localparam logic [2:0] KMAX = 3'(MAX_KEYS);
  logic [15:0] r_entry, r_r;
  logic [2:0]  r_kcnt;
  logic [7:0]  r_a, r_b;
  logic        r_t, r_k7, r_alarm;
  logic        w_accept, w_legal;
  logic [15:0] w_bus, w_rmux;
  // Kc takes priority: a key arriving alongside the clear is dropped
  assign w_accept = key_valid && key_code <= 4'd9 && r_kcnt < KMAX && !Kc;
  assign w_legal  = r_kcnt == KMAX && r_entry[15:12] <= 4'd9 && r_entry[11:8] <= 4'd9 &&
                    r_entry[7:4] <= 4'd9 && r_entry[3:0] <= 4'd9 &&
                    r_entry[15:8] <= HOUR_MAX && r_entry[7:0] <= MIN_MAX;
  assign w_bus  = Ea ? {r_a, r_b} : 16'h0000;
  assign w_rmux = s == 2'd0 ? w_bus : s == 2'd1 ? now_hhmm : s == 2'd2 ? 16'h0000 : r_r;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_entry <= '0;
      r_kcnt  <= '0;
      r_t     <= 1'b0;
      r_k7    <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_r     <= '0;
      r_alarm <= 1'b0;
    end else begin
      r_entry <= Kc ? 16'h0000 : w_accept ? {r_entry[11:0], key_code} : r_entry;
      r_kcnt  <= Kc ? 3'd0 : w_accept ? r_kcnt + 3'd1 : r_kcnt;
      r_t     <= w_accept;
      r_k7    <= w_legal;
      if (La) r_a <= r_entry[15:8];
      if (Lb) r_b <= r_entry[7:0];
      if (Lr) r_r <= w_rmux;
      r_alarm <= Er && (r_r == now_hhmm);
    end
  end
  assign t     = r_t;
  assign k7    = r_k7;
  assign a_q   = r_a;
  assign b_q   = r_b;
  assign r_q   = r_r;
  assign alarm = r_alarm;
endmodule

// File: tb/tb_timer_set_datapath.sv
// tb_timer_set_datapath: directed vector table plus randomized cycles against a digit-queue model.
module tb_timer_set_datapath;
  logic        clk = 1'b0;
  logic        rst_n, key_valid, Kc, La, Lb, Ea, Lr, Er;
  logic [3:0]  key_code;
  logic [15:0] now_hhmm;
  logic [1:0]  s;
  logic        t, k7, alarm;
  logic [7:0]  a_q, b_q;
  logic [15:0] r_q;
  int total = 0, bad = 0;

  timer_set_datapath dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code), .now_hhmm(now_hhmm),
    .Kc(Kc), .La(La), .Lb(Lb), .Ea(Ea), .s(s), .Lr(Lr), .Er(Er),
    .t(t), .k7(k7), .a_q(a_q), .b_q(b_q), .r_q(r_q), .alarm(alarm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst_n, kv; logic [3:0] code; logic kc, la, lb, ea; logic [1:0] s; logic lr, er;
    logic [15:0] now; logic et, ek, eal;
  } vec_t;

  int dq[$];
  logic m_t, m_k7, m_al;
  logic [7:0] m_a, m_b;
  logic [15:0] m_r;

  function automatic vec_t mk(input logic rn, kv, input logic [3:0] code, input logic kc, la, lb, ea,
                              input logic [1:0] sel, input logic lr, er, input logic [15:0] now,
                              input logic et, ek, eal);
    vec_t v;
    v.rst_n = rn; v.kv = kv; v.code = code; v.kc = kc; v.la = la; v.lb = lb; v.ea = ea;
    v.s = sel; v.lr = lr; v.er = er; v.now = now; v.et = et; v.ek = ek; v.eal = eal;
    return v;
  endfunction

  function automatic vec_t key(input logic [3:0] c, input logic et, ek);
    return mk(1, 1, c, 0, 0, 0, 0, 0, 0, 0, 16'h0, et, ek, 0);
  endfunction

  function automatic vec_t idle(input logic ek);
    return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0, ek, 0);
  endfunction

  function automatic logic [15:0] entry_val();
    logic [15:0] e = 16'h0;
    foreach (dq[i]) e = {e[11:0], 4'(dq[i])};
    return e;
  endfunction

  task automatic check(input string name, input logic [15:0] act, exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input vec_t v);
    logic [15:0] e, bus;
    logic acc, leg;
    int hr, mn;
    e = entry_val();
    hr = dq.size() == 4 ? dq[0] * 10 + dq[1] : 99;
    mn = dq.size() == 4 ? dq[2] * 10 + dq[3] : 99;
    leg = hr <= 23 && mn <= 59;
    if (!v.rst_n) begin
      dq.delete();
      m_t = 0; m_k7 = 0; m_al = 0; m_a = 0; m_b = 0; m_r = 0;
    end else begin
      acc = v.kv && v.code <= 9 && dq.size() < 4 && !v.kc;
      bus = v.ea ? {m_a, m_b} : 16'h0;
      m_al = v.er && (m_r == v.now);
      if (v.lr) m_r = v.s == 0 ? bus : v.s == 1 ? v.now : v.s == 2 ? 16'h0 : m_r;
      if (v.la) m_a = e[15:8];
      if (v.lb) m_b = e[7:0];
      m_t = acc;
      m_k7 = leg;
      if (v.kc) dq.delete();
      else if (acc) dq.push_back(int'(v.code));
    end
  endtask

  task automatic step(input vec_t v);
    rst_n = v.rst_n; key_valid = v.kv; key_code = v.code; Kc = v.kc; La = v.la; Lb = v.lb;
    Ea = v.ea; s = v.s; Lr = v.lr; Er = v.er; now_hhmm = v.now;
    model_edge(v);
    @(posedge clk);
    #1;
    check("t", 16'(t), 16'(m_t));
    check("k7", 16'(k7), 16'(m_k7));
    check("a_q", 16'(a_q), 16'(m_a));
    check("b_q", 16'(b_q), 16'(m_b));
    check("r_q", r_q, m_r);
    check("alarm", 16'(alarm), 16'(m_al));
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    tbl.push_back(mk(0, 1, 4'h5, 1, 1, 1, 1, 2'd3, 1, 1, 16'h0, 0, 0, 0));
    tbl.push_back(idle(0));
    tbl.push_back(key(1, 1, 0)); tbl.push_back(key(2, 1, 0));
    tbl.push_back(key(3, 1, 0)); tbl.push_back(key(0, 1, 0));
    tbl.push_back(idle(1));
    tbl.push_back(key(4, 0, 1));
    tbl.push_back(key(4'hB, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 16'h0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 4'h5, 1, 0, 0, 0, 0, 0, 0, 16'h0, 0, 1, 0));
    tbl.push_back(idle(0));
    tbl.push_back(key(2, 1, 0)); tbl.push_back(key(5, 1, 0));
    tbl.push_back(key(0, 1, 0)); tbl.push_back(key(0, 1, 0));
    tbl.push_back(idle(0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0, 0));
    tbl.push_back(key(0, 1, 0)); tbl.push_back(key(9, 1, 0));
    tbl.push_back(key(6, 1, 0)); tbl.push_back(key(1, 1, 0));
    tbl.push_back(idle(0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0, 0));
    tbl.push_back(key(0, 1, 0)); tbl.push_back(key(7, 1, 0));
    tbl.push_back(key(4, 1, 0)); tbl.push_back(key(5, 1, 0));
    tbl.push_back(idle(1));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 16'h0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 2'd0, 1, 0, 16'h0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0744, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0745, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0746, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0745, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 16'h0, 0, 1, 0));
    tbl.push_back(idle(0));
    foreach (tbl[i]) begin
      step(tbl[i]);
      check("tbl_t", 16'(t), 16'(tbl[i].et));
      check("tbl_k7", 16'(k7), 16'(tbl[i].ek));
      check("tbl_alarm", 16'(alarm), 16'(tbl[i].eal));
    end
    check("dir_a_q", 16'(a_q), 16'h0007);
    check("dir_b_q", 16'(b_q), 16'h0045);
    check("dir_r_q", r_q, 16'h0745);
    for (int n = 0; n < 600; n++) begin
      v.rst_n = $urandom_range(0, 59) != 0;
      v.kv = $urandom_range(0, 2) != 0;
      v.code = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      v.kc = $urandom_range(0, 7) == 0;
      v.la = $urandom_range(0, 3) == 0;
      v.lb = $urandom_range(0, 3) == 0;
      v.ea = 1'($urandom);
      v.s = 2'($urandom);
      v.lr = $urandom_range(0, 2) == 0;
      v.er = 1'($urandom);
      v.now = $urandom_range(0, 2) == 0 ? m_r : 16'($urandom);
      step(v);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
